// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: merges cache stalls, load-use, mul/div
// occupancy and MEM-stage exceptions into per-register hold/bubble strobes.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_stall,
    input  logic        dcache_stall,
    input  logic        idex_load,
    input  logic [4:0]  idex_rt,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_rs_used,
    input  logic        ifid_rt_used,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_exe_stall,
    output logic        exe_mem_stall,
    output logic        if_id_flush,
    output logic        id_exe_flush,
    output logic        exe_mem_flush,
    output logic        mem_wb_flush,
    output logic        md_busy,
    output logic        md_done,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {IDLE, MD_BUSY, EXC_WAIT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       epc;

    logic run, exc_fire, dc_hold, md_go, md_stall, load_use, lu, ic;

    always_comb begin
        run      = (state != EXC_WAIT);
        // An exception flushes only once MEM is free; EXC_WAIT replays the latched one.
        exc_fire = rst_n && !dcache_stall && ((run && exc_req) || !run);
        dc_hold  = rst_n && dcache_stall;
        md_go    = rst_n && (state == IDLE) && md_start && !exc_req && !dcache_stall;
        md_stall = !exc_fire && (md_go || (rst_n && (state == MD_BUSY) && (cnt != '0)));
        load_use = idex_load && (idex_rt != 5'd0) &&
                   ((ifid_rs_used && (ifid_rs == idex_rt)) ||
                    (ifid_rt_used && (ifid_rt == idex_rt)));
        // Deeper holds already freeze the upstream stages, so they mask shallower causes.
        lu       = rst_n && load_use && !exc_fire && !dc_hold && !md_stall;
        ic       = rst_n && icache_stall && !exc_fire && !dc_hold && !md_stall && !load_use;

        pc_stall       = dc_hold || md_stall || lu || ic;
        if_id_stall    = dc_hold || md_stall || lu;
        id_exe_stall   = dc_hold || md_stall;
        exe_mem_stall  = dc_hold;
        if_id_flush    = exc_fire || ic;
        id_exe_flush   = exc_fire || lu;
        exe_mem_flush  = exc_fire || (md_stall && !dc_hold);
        mem_wb_flush   = exc_fire || dc_hold;
        md_busy        = md_stall;
        // A pending exception squashes the mul/div, so its completion is not reported.
        md_done        = rst_n && (state == MD_BUSY) && (cnt == '0) && !exc_req;
        redirect_valid = exc_fire;
        redirect_pc    = !exc_fire ? 32'd0 : (run ? exc_pc : epc);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            epc   <= '0;
        end else if (state == EXC_WAIT) begin
            if (!dcache_stall) begin
                state <= IDLE;
                cnt   <= '0;
            end
        end else if (exc_req) begin
            cnt <= '0;
            if (dcache_stall) begin
                state <= EXC_WAIT;
                epc   <= exc_pc;
            end else begin
                state <= IDLE;
            end
        end else if (state == IDLE) begin
            if (md_start && !dcache_stall) begin
                state <= MD_BUSY;
                cnt   <= md_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end
        end else begin
            // The unit keeps computing while MEM is stalled.
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// against a stage-depth reference model.
module tb_pipe_hazard_ctrl;

    localparam int MUL_N = 2;
    localparam int DIV_N = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_stall, dcache_stall, idex_load;
    logic [4:0]  idex_rt, ifid_rs, ifid_rt;
    logic        ifid_rs_used, ifid_rt_used, md_start, md_is_div, exc_req;
    logic [31:0] exc_pc;
    logic        pc_stall, if_id_stall, id_exe_stall, exe_mem_stall;
    logic        if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush;
    logic        md_busy, md_done, redirect_valid;
    logic [31:0] redirect_pc;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: in-flight mul/div length and cycles elapsed; deferred exception.
    bit          m_act  = 0;
    int          m_n    = 0;
    int          m_el   = 0;
    bit          m_pend = 0;
    logic [31:0] m_pc   = 0;

    pipe_hazard_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .idex_load(idex_load), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .ifid_rs_used(ifid_rs_used), .ifid_rt_used(ifid_rt_used),
        .md_start(md_start), .md_is_div(md_is_div),
        .exc_req(exc_req), .exc_pc(exc_pc),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .id_exe_stall(id_exe_stall), .exe_mem_stall(exe_mem_stall),
        .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush),
        .exe_mem_flush(exe_mem_flush), .mem_wb_flush(mem_wb_flush),
        .md_busy(md_busy), .md_done(md_done),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    logic [3:0]  obs_st, obs_fl;
    logic [42:0] obs;
    assign obs_st = {pc_stall, if_id_stall, id_exe_stall, exe_mem_stall};
    assign obs_fl = {if_id_flush, id_exe_flush, exe_mem_flush, mem_wb_flush};
    assign obs    = {obs_st, obs_fl, md_busy, md_done, redirect_valid, redirect_pc};

    // Stalls are expressed as a hold depth from the PC end (registers 0=PC..4=MEM/WB):
    // every register below the depth holds and the one at the depth takes a bubble.
    function automatic logic [42:0] model_out();
        logic [4:0]  hold, bub;
        logic        busy, done, rv, lu;
        logic [31:0] rp;
        int          depth;
        hold = '0; bub = '0; busy = 0; done = 0; rv = 0; rp = '0; depth = 0;
        if (rst_n) begin
            if (!dcache_stall && (m_pend || exc_req)) begin
                bub = 5'b11110;
                rv  = 1;
                rp  = m_pend ? m_pc : exc_pc;
            end else begin
                if (!m_pend) begin
                    busy = m_act ? (m_el < m_n) : (md_start && !exc_req && !dcache_stall);
                    done = m_act && (m_el == m_n) && !exc_req;
                end
                lu = idex_load && idex_rt != 0 &&
                     ((ifid_rs_used && ifid_rs == idex_rt) || (ifid_rt_used && ifid_rt == idex_rt));
                if (dcache_stall)      depth = 4;
                else if (busy)         depth = 3;
                else if (lu)           depth = 2;
                else if (icache_stall) depth = 1;
                for (int i = 0; i < 5; i++) hold[i] = (i < depth);
                if (depth > 0) bub[depth] = 1'b1;
            end
        end
        return {hold[0], hold[1], hold[2], hold[3], bub[1], bub[2], bub[3], bub[4],
                busy, done, rv, rp};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_act = 0; m_el = 0; m_n = 0; m_pend = 0; m_pc = 0;
        end else if (!dcache_stall && (m_pend || exc_req)) begin
            m_pend = 0; m_act = 0;
        end else if (m_pend) begin
            m_pend = 1;
        end else if (exc_req) begin
            m_pend = 1; m_pc = exc_pc; m_act = 0;
        end else if (m_act) begin
            if (m_el == m_n) m_act = 0;
            else m_el++;
        end else if (md_start && !dcache_stall) begin
            m_act = 1; m_n = md_is_div ? DIV_N : MUL_N; m_el = 1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        icache_stall = 0; dcache_stall = 0; idex_load = 0; idex_rt = 0;
        ifid_rs = 0; ifid_rt = 0; ifid_rs_used = 0; ifid_rt_used = 0;
        md_start = 0; md_is_div = 0; exc_req = 0; exc_pc = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            md_start = 1; icache_stall = 1'($urandom); idex_load = 1;
            idex_rt = 5'd3; ifid_rs = 5'd3; ifid_rs_used = 1;
            exc_req = 1'($urandom); exc_pc = $urandom;
            @(negedge clk);
            n_tests++;
            if (obs !== 43'd0) begin
                n_fail++; $display("FAIL reset_outputs got %h want 0", obs);
            end
            adv();
        end
        clear_inputs();
        md_start = 1; rst_n = 1;
        @(negedge clk);
        n_tests++;
        if ({md_busy, md_done, pc_stall, exe_mem_flush} !== 4'b1011) begin
            n_fail++; $display("FAIL reset_release_start got %b want 1011",
                               {md_busy, md_done, pc_stall, exe_mem_flush});
        end
        adv();
        @(negedge clk);
        n_tests++;
        if ({md_busy, md_done} !== 2'b10) begin
            n_fail++; $display("FAIL reset_md_busy_entered got %b want 10", {md_busy, md_done});
        end
        adv();
        @(negedge clk);
        n_tests++;
        if ({md_busy, md_done} !== 2'b01) begin
            n_fail++; $display("FAIL reset_mul_done got %b want 01", {md_busy, md_done});
        end
        adv();
        md_start = 0;
        adv();
    endtask

    task automatic test_div();
        int busy_cnt, done_at, bad_flush;
        clear_inputs();
        md_start = 1; md_is_div = 1;
        busy_cnt = 0; done_at = -1; bad_flush = 0;
        for (int i = 0; i < 60 && done_at < 0; i++) begin
            @(negedge clk);
            if (md_done) done_at = i;
            if (md_busy) begin
                busy_cnt++;
                if (!(exe_mem_flush && pc_stall && id_exe_stall && !exe_mem_stall)) bad_flush++;
            end
            adv();
        end
        md_start = 0;
        n_tests++;
        if (done_at < 0) begin
            n_fail++; $display("FAIL div_timeout md_done never seen within 60 cycles");
        end
        n_tests++;
        if (busy_cnt != DIV_N || done_at != DIV_N) begin
            n_fail++; $display("FAIL div_length busy=%0d done_idx=%0d want %0d/%0d",
                               busy_cnt, done_at, DIV_N, DIV_N);
        end
        n_tests++;
        if (bad_flush != 0) begin
            n_fail++; $display("FAIL div_exe_mem_flush bad cycles=%0d want 0", bad_flush);
        end
        adv();
    endtask

    task automatic test_load_use();
        clear_inputs();
        idex_load = 1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rs_used = 1;
        @(negedge clk);
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush, id_exe_stall, if_id_flush} !== 5'b11100) begin
            n_fail++; $display("FAIL load_use_rs got %b want 11100",
                               {pc_stall, if_id_stall, id_exe_flush, id_exe_stall, if_id_flush});
        end
        idex_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush} !== 3'b000) begin
            n_fail++; $display("FAIL load_use_r0 got %b want 000", {pc_stall, if_id_stall, id_exe_flush});
        end
        idex_rt = 5'd7; ifid_rt = 5'd7; ifid_rt_used = 1; ifid_rs_used = 0;
        #1;
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush} !== 3'b111) begin
            n_fail++; $display("FAIL load_use_rt got %b want 111", {pc_stall, if_id_stall, id_exe_flush});
        end
        ifid_rt_used = 0;
        #1;
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush} !== 3'b000) begin
            n_fail++; $display("FAIL load_use_unused got %b want 000", {pc_stall, if_id_stall, id_exe_flush});
        end
        adv();
    endtask

    task automatic test_exc_md();
        clear_inputs();
        md_start = 1; md_is_div = 1;
        for (int i = 0; i < DIV_N - 10; i++) adv();
        exc_req = 1; exc_pc = 32'hBFC0_0380;
        @(negedge clk);
        n_tests++;
        if ({obs_st, obs_fl, md_busy, redirect_valid} !== 10'b0000_1111_01 ||
            redirect_pc !== 32'hBFC0_0380) begin
            n_fail++; $display("FAIL exc_md_flush got st=%b fl=%b busy=%b rv=%b pc=%h want 0000/1111/0/1/bfc00380",
                               obs_st, obs_fl, md_busy, redirect_valid, redirect_pc);
        end
        adv();
        exc_req = 0; md_start = 0;
        @(negedge clk);
        n_tests++;
        if ({md_busy, redirect_valid, obs_st} !== 6'd0) begin
            n_fail++; $display("FAIL exc_md_idle got busy=%b rv=%b st=%b want all 0",
                               md_busy, redirect_valid, obs_st);
        end
        adv();
    endtask

    task automatic test_dcache_exc();
        clear_inputs();
        dcache_stall = 1; exc_req = 1; exc_pc = 32'h8000_0180;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if ({obs_st, obs_fl, redirect_valid} !== 9'b1111_0001_0) begin
                n_fail++; $display("FAIL dcache_exc_hold cyc%0d got st=%b fl=%b rv=%b want 1111/0001/0",
                                   c, obs_st, obs_fl, redirect_valid);
            end
            adv();
            exc_req = 0; exc_pc = 32'hDEAD_BEEF;
        end
        dcache_stall = 0;
        @(negedge clk);
        n_tests++;
        if ({obs_st, obs_fl, redirect_valid} !== 9'b0000_1111_1 || redirect_pc !== 32'h8000_0180) begin
            n_fail++; $display("FAIL dcache_exc_redirect got st=%b fl=%b rv=%b pc=%h want 0000/1111/1/80000180",
                               obs_st, obs_fl, redirect_valid, redirect_pc);
        end
        adv();
        @(negedge clk);
        n_tests++;
        if (redirect_valid !== 1'b0 || obs_fl !== 4'b0000) begin
            n_fail++; $display("FAIL dcache_exc_after got rv=%b fl=%b want 0/0000", redirect_valid, obs_fl);
        end
        adv();
    endtask

    task automatic test_icache();
        clear_inputs();
        icache_stall = 1; idex_load = 1; idex_rt = 5'd9; ifid_rs = 5'd9; ifid_rs_used = 1;
        @(negedge clk);
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush, if_id_flush} !== 4'b1110) begin
            n_fail++; $display("FAIL icache_vs_load_use got %b want 1110",
                               {pc_stall, if_id_stall, id_exe_flush, if_id_flush});
        end
        idex_load = 0;
        #1;
        n_tests++;
        if ({pc_stall, if_id_stall, id_exe_flush, if_id_flush} !== 4'b1001) begin
            n_fail++; $display("FAIL icache_alone got %b want 1001",
                               {pc_stall, if_id_stall, id_exe_flush, if_id_flush});
        end
        adv();
    endtask

    task automatic test_random();
        logic [42:0] exp;
        int rfail;
        rfail = 0;
        for (int i = 0; i < 4000 && rfail < 30; i++) begin
            rst_n        = ($urandom_range(0, 199) != 0);
            icache_stall = ($urandom_range(0, 3) == 0);
            dcache_stall = ($urandom_range(0, 4) == 0);
            exc_req      = ($urandom_range(0, 29) == 0);
            exc_pc       = $urandom;
            md_start     = ($urandom_range(0, 5) == 0);
            md_is_div    = ($urandom_range(0, 3) == 0);
            idex_load    = ($urandom_range(0, 2) == 0);
            idex_rt      = 5'($urandom_range(0, 3));
            ifid_rs      = 5'($urandom_range(0, 3));
            ifid_rt      = 5'($urandom_range(0, 3));
            ifid_rs_used = 1'($urandom);
            ifid_rt_used = 1'($urandom);
            @(negedge clk);
            exp = model_out();
            n_tests++;
            if (obs !== exp) begin
                n_fail++; rfail++;
                $display("FAIL random_cycle%0d got %h want %h", i, obs, exp);
            end
            adv();
        end
        rst_n = 1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_div();
        test_load_use();
        test_exc_md();
        test_dcache_exc();
        test_icache();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
